// File: rtl/ft_pkg.sv
// Shared types and constants for the lockstep fault-tolerance controller.
package ft_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BLOCK   = 3'd1,
    RESTORE = 3'd2,
    RESUME  = 3'd3,
    FATAL   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    AGREE  = 2'd0,
    MASKED = 2'd1,
    ERROR  = 2'd2,
    NONE   = 2'd3
  } vote_t;

  localparam int LANE_DMR = 2;
  localparam int LANE_TMR = 3;
  localparam int RF_ADDR_WIDTH_DEF = 5;

  function automatic int rf_depth(input int aw);
    return 1 << aw;
  endfunction

  localparam int RF_DEPTH = rf_depth(RF_ADDR_WIDTH_DEF);

endpackage

// File: rtl/ft_voter.sv
// Combinational tuple voter: compares the masked retire tuples of all lanes
// and reports agreement, a masked single-lane fault (TMR) or an unresolvable error.
module ft_voter
  import ft_pkg::*;
#(
  parameter int NUM_LANES  = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic [NUM_LANES-1:0]            commit_i,
  input  logic [NUM_LANES-1:0]            we_i,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] pc_i,
  output vote_t                           vote_o,
  output logic                            commit_o,
  output logic                            we_o,
  output logic [ADDR_WIDTH-1:0]           addr_o,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic [DATA_WIDTH-1:0]           pc_o,
  output logic [NUM_LANES-1:0]            odd_o
);

  localparam int TW = 2 + ADDR_WIDTH + 2 * DATA_WIDTH;

  logic [TW-1:0] tup_s [NUM_LANES];
  logic [TW-1:0] agreed_s;

  // Fields that carry no meaning are zeroed so they cannot cause false mismatches
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      tup_s[k] = {commit_i[k], we_i[k],
                  we_i[k]     ? addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] : {ADDR_WIDTH{1'b0}},
                  we_i[k]     ? data_i[k*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}},
                  commit_i[k] ? pc_i[k*DATA_WIDTH +: DATA_WIDTH]   : {DATA_WIDTH{1'b0}}};
    end
  end

  if (NUM_LANES == LANE_TMR) begin : g_tmr
    logic eq01_s, eq02_s, eq12_s;
    assign eq01_s = (tup_s[0] == tup_s[1]);
    assign eq02_s = (tup_s[0] == tup_s[2]);
    assign eq12_s = (tup_s[1] == tup_s[2]);

    // Two equal pairs imply the third by transitivity, so the masked cases are exclusive
    always_comb begin
      odd_o    = '0;
      agreed_s = tup_s[0];
      if (commit_i == '0) begin
        vote_o = NONE;
      end else if (eq01_s && eq12_s) begin
        vote_o = AGREE;
      end else if (eq01_s) begin
        vote_o   = MASKED;
        odd_o[2] = 1'b1;
      end else if (eq02_s) begin
        vote_o   = MASKED;
        odd_o[1] = 1'b1;
      end else if (eq12_s) begin
        vote_o   = MASKED;
        odd_o[0] = 1'b1;
        agreed_s = tup_s[1];
      end else begin
        vote_o = ERROR;
      end
    end
  end else begin : g_dmr
    // With two lanes a mismatch is detectable but not attributable
    always_comb begin
      odd_o    = '0;
      agreed_s = tup_s[0];
      if (commit_i == '0) begin
        vote_o = NONE;
      end else if (tup_s[0] == tup_s[1]) begin
        vote_o = AGREE;
      end else begin
        vote_o = ERROR;
      end
    end
  end

  assign commit_o = agreed_s[TW-1];
  assign we_o     = agreed_s[TW-2];
  assign addr_o   = agreed_s[2*DATA_WIDTH +: ADDR_WIDTH];
  assign data_o   = agreed_s[DATA_WIDTH +: DATA_WIDTH];
  assign pc_o     = agreed_s[0 +: DATA_WIDTH];

endmodule

// File: rtl/ft_lockstep_ctrl.sv
// Lockstep controller: votes on lane retires, keeps the shadow register file and
// checkpoint PC, and drives the block/restore/resume sequence after an error.
module ft_lockstep_ctrl
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 3,
  parameter int MAX_RETRY  = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_n,
  input  logic [NUM_LANES-1:0]            commit_i,
  input  logic [NUM_LANES-1:0]            we_i,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] pc_i,
  output logic                            rf_we_o,
  output logic [ADDR_WIDTH-1:0]           rf_addr_o,
  output logic [DATA_WIDTH-1:0]           rf_data_o,
  output logic [DATA_WIDTH-1:0]           spc_o,
  output logic                            resume_o,
  output logic                            fetch_block_o,
  output logic [NUM_LANES-1:0]            fault_lane_o,
  output logic                            fatal_o,
  output logic [CNT_WIDTH-1:0]            err_cnt_o
);

  localparam int DEPTH = rf_depth(ADDR_WIDTH);
  localparam int RW    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};

  if (NUM_LANES != LANE_DMR && NUM_LANES != LANE_TMR) begin : g_bad_lanes
    $error("ft_lockstep_ctrl: NUM_LANES must be 2 or 3");
  end

  vote_t                  vote_s;
  logic                   v_commit_s;
  logic                   v_we_s;
  logic [ADDR_WIDTH-1:0]  v_addr_s;
  logic [DATA_WIDTH-1:0]  v_data_s;
  logic [DATA_WIDTH-1:0]  v_pc_s;
  logic [NUM_LANES-1:0]   v_odd_s;
  logic                   accept_s;
  logic [CNT_WIDTH-1:0]   err_cnt_d;

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  shadow_q [DEPTH];
  logic [DATA_WIDTH-1:0]  spc_q;
  logic                   rf_we_q;
  logic [ADDR_WIDTH-1:0]  rf_addr_q;
  logic                   resume_q;
  logic                   fetch_block_q;
  logic [NUM_LANES-1:0]   fault_q;
  logic                   fatal_q;
  logic [CNT_WIDTH-1:0]   err_cnt_q;
  logic [RW-1:0]          retry_q;

  ft_voter #(
    .NUM_LANES  (NUM_LANES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_voter (
    .commit_i (commit_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .pc_i     (pc_i),
    .vote_o   (vote_s),
    .commit_o (v_commit_s),
    .we_o     (v_we_s),
    .addr_o   (v_addr_s),
    .data_o   (v_data_s),
    .pc_o     (v_pc_s),
    .odd_o    (v_odd_s)
  );

  assign accept_s  = (state_q == IDLE) && ((vote_s == AGREE) || (vote_s == MASKED));
  assign err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_WIDTH'(1);

  // Shadow register file; entry 0 stays zero because it is never written
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (accept_s && v_commit_s && v_we_s && (v_addr_s != '0)) begin
      shadow_q[v_addr_s] <= v_data_s;
    end
  end

  // Replay FSM with registered status outputs
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      spc_q         <= '0;
      rf_we_q       <= 1'b0;
      rf_addr_q     <= '0;
      resume_q      <= 1'b0;
      fetch_block_q <= 1'b0;
      fault_q       <= '0;
      fatal_q       <= 1'b0;
      err_cnt_q     <= '0;
      retry_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          case (vote_s)
            AGREE, MASKED: begin
              spc_q   <= v_pc_s;
              retry_q <= '0;
              if (vote_s == MASKED) begin
                fault_q   <= fault_q | v_odd_s;
                err_cnt_q <= err_cnt_d;
              end
            end
            ERROR: begin
              err_cnt_q     <= err_cnt_d;
              fetch_block_q <= 1'b1;
              if (retry_q == RW'(MAX_RETRY)) begin
                state_q <= FATAL;
                fatal_q <= 1'b1;
              end else begin
                retry_q <= retry_q + RW'(1);
                state_q <= BLOCK;
              end
            end
            default: begin
            end
          endcase
        end
        BLOCK: begin
          // Let in-flight retires drain before restoring state
          if (commit_i == '0) begin
            state_q   <= RESTORE;
            rf_we_q   <= 1'b1;
            rf_addr_q <= '0;
          end
        end
        RESTORE: begin
          if (rf_addr_q == ADDR_LAST) begin
            state_q   <= RESUME;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            resume_q  <= 1'b1;
          end else begin
            rf_addr_q <= rf_addr_q + ADDR_WIDTH'(1);
          end
        end
        RESUME: begin
          resume_q      <= 1'b0;
          fetch_block_q <= 1'b0;
          state_q       <= IDLE;
        end
        FATAL: begin
          fetch_block_q <= 1'b1;
          fatal_q       <= 1'b1;
        end
        default: begin
          state_q       <= FATAL;
          fetch_block_q <= 1'b1;
          fatal_q       <= 1'b1;
        end
      endcase
    end
  end

  assign rf_we_o       = rf_we_q;
  assign rf_addr_o     = rf_addr_q;
  assign rf_data_o     = rf_we_q ? shadow_q[rf_addr_q] : '0;
  assign spc_o         = spc_q;
  assign resume_o      = resume_q;
  assign fetch_block_o = fetch_block_q;
  assign fault_lane_o  = fault_q;
  assign fatal_o       = fatal_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_ft_lockstep_ctrl.sv
// Directed bench: one TMR and one DMR controller driven through vote, restore,
// retry-to-fatal and mid-restore reset scenarios with hand-computed expectations.
module tb_ft_lockstep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [2:0]  t_commit, t_we;
  logic [14:0] t_addr;
  logic [95:0] t_data, t_pc;
  logic        t_rf_we, t_resume, t_fb, t_fatal;
  logic [4:0]  t_rf_addr;
  logic [31:0] t_rf_data, t_spc;
  logic [2:0]  t_fault;
  logic [7:0]  t_err;

  logic [1:0]  d_commit, d_we;
  logic [9:0]  d_addr;
  logic [63:0] d_data, d_pc;
  logic        d_rf_we, d_resume, d_fb, d_fatal;
  logic [4:0]  d_rf_addr;
  logic [31:0] d_rf_data, d_spc;
  logic [1:0]  d_fault;
  logic [7:0]  d_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [31:0] exp_rf [32];
  int cnt;

  ft_lockstep_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_LANES(3), .MAX_RETRY(3), .CNT_WIDTH(8)) dut_t (
    .clk_i(clk), .rst_n(rst_n), .commit_i(t_commit), .we_i(t_we), .addr_i(t_addr),
    .data_i(t_data), .pc_i(t_pc), .rf_we_o(t_rf_we), .rf_addr_o(t_rf_addr),
    .rf_data_o(t_rf_data), .spc_o(t_spc), .resume_o(t_resume), .fetch_block_o(t_fb),
    .fault_lane_o(t_fault), .fatal_o(t_fatal), .err_cnt_o(t_err)
  );

  ft_lockstep_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_LANES(2), .MAX_RETRY(3), .CNT_WIDTH(8)) dut_d (
    .clk_i(clk), .rst_n(rst_n), .commit_i(d_commit), .we_i(d_we), .addr_i(d_addr),
    .data_i(d_data), .pc_i(d_pc), .rf_we_o(d_rf_we), .rf_addr_o(d_rf_addr),
    .rf_data_o(d_rf_data), .spc_o(d_spc), .resume_o(d_resume), .fetch_block_o(d_fb),
    .fault_lane_o(d_fault), .fatal_o(d_fatal), .err_cnt_o(d_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tdrive(input logic [2:0] c, input logic [4:0] a, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] pc);
    t_commit = c;
    t_we     = c;
    t_addr   = {a, a, a};
    t_data   = {d2, d1, d0};
    t_pc     = {pc, pc, pc};
  endtask

  task automatic ddrive(input logic [1:0] c, input logic [4:0] a, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [31:0] pc);
    d_commit = c;
    d_we     = c;
    d_addr   = {a, a};
    d_data   = {d1, d0};
    d_pc     = {pc, pc};
  endtask

  // Walks a TMR restore that has just started at address 0
  task automatic t_scan(input string tag);
    for (int i = 0; i < 32; i++) begin
      check({tag, "_we"}, t_rf_we, 64'd1);
      check({tag, "_addr"}, t_rf_addr, i);
      check({tag, "_data"}, t_rf_data, exp_rf[i]);
      step();
    end
  endtask

  task automatic d_err_recover(input string tag);
    ddrive(2'b11, 5'd6, 32'hA, 32'hB, 32'h300);
    step();
    check({tag, "_fb"}, d_fb, 64'd1);
    check({tag, "_fatal"}, d_fatal, 64'd0);
    ddrive(2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    check({tag, "_rfwe"}, d_rf_we, 64'd1);
    repeat (32) step();
    check({tag, "_resume"}, d_resume, 64'd1);
    step();
    check({tag, "_fb_off"}, d_fb, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    tdrive(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    ddrive(2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
    repeat (3) step();
    check("rst_t_fb", t_fb, 64'd0);
    check("rst_t_spc", t_spc, 64'd0);
    check("rst_t_err", t_err, 64'd0);
    check("rst_t_fault", t_fault, 64'd0);
    check("rst_t_rfwe", t_rf_we, 64'd0);
    check("rst_t_resume", t_resume, 64'd0);
    check("rst_t_fatal", t_fatal, 64'd0);
    check("rst_d_fb", d_fb, 64'd0);
    rst_n = 1'b1;
    step();

    // TMR full agreement
    tdrive(3'b111, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100);
    step();
    exp_rf[5] = 32'hDEADBEEF;
    check("agree_spc", t_spc, 64'h100);
    check("agree_err", t_err, 64'd0);
    check("agree_fb", t_fb, 64'd0);

    // TMR lane 1 outvoted
    tdrive(3'b111, 5'd3, 32'hAA, 32'h1, 32'hAA, 32'h104);
    step();
    exp_rf[3] = 32'hAA;
    check("mask_fault", t_fault, 64'h2);
    check("mask_err", t_err, 64'd1);
    check("mask_fb", t_fb, 64'd0);
    check("mask_spc", t_spc, 64'h104);

    // TMR no majority, commit held for three cycles
    tdrive(3'b111, 5'd7, 32'h1, 32'h2, 32'h3, 32'h108);
    step();
    check("err_fb", t_fb, 64'd1);
    check("err_rfwe0", t_rf_we, 64'd0);
    check("err_cnt", t_err, 64'd2);
    check("err_spc", t_spc, 64'h104);
    tdrive(3'b111, 5'd7, 32'h4, 32'h5, 32'h6, 32'h10C);
    step();
    check("drain1_fb", t_fb, 64'd1);
    check("drain1_rfwe", t_rf_we, 64'd0);
    check("drain1_err", t_err, 64'd2);
    tdrive(3'b111, 5'd9, 32'h7, 32'h7, 32'h7, 32'h110);
    step();
    check("drain2_fb", t_fb, 64'd1);
    check("drain2_rfwe", t_rf_we, 64'd0);
    check("drain2_spc", t_spc, 64'h104);
    tdrive(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    t_scan("tmr_restore");
    check("tmr_resume", t_resume, 64'd1);
    check("tmr_resume_fb", t_fb, 64'd1);
    check("tmr_resume_spc", t_spc, 64'h104);
    check("tmr_resume_err", t_err, 64'd2);
    step();
    check("tmr_post_resume", t_resume, 64'd0);
    check("tmr_post_fb", t_fb, 64'd0);

    // DMR detect and replay
    ddrive(2'b11, 5'd9, 32'h55, 32'h55, 32'h1FC);
    step();
    check("dmr_agree_spc", d_spc, 64'h1FC);
    check("dmr_agree_err", d_err, 64'd0);
    ddrive(2'b11, 5'd4, 32'h1, 32'h2, 32'h200);
    step();
    check("dmr_err_fb", d_fb, 64'd1);
    check("dmr_err_cnt", d_err, 64'd1);
    check("dmr_err_spc", d_spc, 64'h1FC);
    ddrive(2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    cnt = 0;
    for (int i = 0; i < 40 && !d_resume; i++) begin
      step();
      if (d_rf_we) begin
        check("dmr_rf_addr", d_rf_addr, cnt);
        if (cnt == 9) check("dmr_rf_data9", d_rf_data, 64'h55);
        if (cnt == 4) check("dmr_rf_data4", d_rf_data, 64'h0);
        cnt++;
      end
    end
    check("dmr_resume", d_resume, 64'd1);
    check("dmr_we_cycles", cnt, 64'd32);
    check("dmr_resume_spc", d_spc, 64'h1FC);
    step();
    check("dmr_post_resume", d_resume, 64'd0);
    check("dmr_post_fb", d_fb, 64'd0);

    // DMR retry counting: an agreed commit clears it, four straight errors are fatal
    ddrive(2'b11, 5'd2, 32'h77, 32'h77, 32'h204);
    step();
    check("retry_agree1_spc", d_spc, 64'h204);
    d_err_recover("retry_a1");
    d_err_recover("retry_a2");
    ddrive(2'b11, 5'd2, 32'h78, 32'h78, 32'h208);
    step();
    check("retry_agree2_spc", d_spc, 64'h208);
    d_err_recover("retry_b1");
    d_err_recover("retry_b2");
    d_err_recover("retry_b3");
    ddrive(2'b11, 5'd6, 32'hC, 32'hD, 32'h30C);
    step();
    check("fatal_flag", d_fatal, 64'd1);
    check("fatal_fb", d_fb, 64'd1);
    check("fatal_err", d_err, 64'd7);
    ddrive(2'b11, 5'd2, 32'h99, 32'h99, 32'h20C);
    repeat (5) step();
    check("fatal_sticky", d_fatal, 64'd1);
    check("fatal_fb_sticky", d_fb, 64'd1);
    check("fatal_spc", d_spc, 64'h208);
    check("fatal_err_hold", d_err, 64'd7);
    check("fatal_rfwe", d_rf_we, 64'd0);
    ddrive(2'b00, 5'd0, 32'h0, 32'h0, 32'h0);

    // Reset in the middle of a TMR restore
    tdrive(3'b111, 5'd7, 32'h1, 32'h2, 32'h3, 32'h400);
    step();
    tdrive(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    repeat (10) step();
    check("midrst_addr", t_rf_addr, 64'd10);
    check("midrst_we", t_rf_we, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_now_we", t_rf_we, 64'd0);
    check("rst_now_addr", t_rf_addr, 64'd0);
    check("rst_now_data", t_rf_data, 64'd0);
    check("rst_now_fb", t_fb, 64'd0);
    check("rst_now_spc", t_spc, 64'd0);
    check("rst_now_err", t_err, 64'd0);
    check("rst_now_fault", t_fault, 64'd0);
    check("rst_now_dfatal", d_fatal, 64'd0);
    check("rst_now_dfb", d_fb, 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
    tdrive(3'b111, 5'd4, 32'h1234, 32'h1234, 32'h1234, 32'h300);
    step();
    exp_rf[4] = 32'h1234;
    check("post_rst_spc", t_spc, 64'h300);
    check("post_rst_err", t_err, 64'd0);
    check("post_rst_fb", t_fb, 64'd0);
    tdrive(3'b111, 5'd7, 32'h1, 32'h2, 32'h3, 32'h304);
    step();
    check("post_rst_err_fb", t_fb, 64'd1);
    check("post_rst_err_cnt", t_err, 64'd1);
    tdrive(3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    t_scan("post_rst_restore");
    check("post_rst_resume", t_resume, 64'd1);
    check("post_rst_resume_spc", t_spc, 64'h300);
    step();
    check("post_rst_fb_off", t_fb, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ft_lockstep_ctrl.md
Name: ft_lockstep_ctrl

Overview:
- Parametrised successor to the single-pair fault-tolerance wrapper.
- Supports DMR (NUM_LANES=2: detect, then replay) and TMR (NUM_LANES=3: majority-vote and mask; replay only when no majority exists).
- Owns the shadow register file, the checkpointed PC and the replay FSM. The FSM streams a full register-file restore to all lanes, then pulses a PC reload.
- Sits between the redundant core lanes' writeback/retire ports and their fetch/RF-restore inputs.

Parameters:
- ADDR_WIDTH, 5: register address width; shadow RF depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: register and PC width.
- NUM_LANES, 3: redundant lanes. Legal values are 2 or 3; elaboration error otherwise.
- MAX_RETRY, 3: consecutive replays tolerated before fatal.
- CNT_WIDTH, 8: width of the saturating error counter.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- commit_i  in  NUM_LANES  lane k retires an instruction this cycle
- we_i  in  NUM_LANES  lane k writes a register on this retire
- addr_i  in  NUM_LANES*ADDR_WIDTH  lane k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- data_i  in  NUM_LANES*DATA_WIDTH  lane k write data
- pc_i  in  NUM_LANES*DATA_WIDTH  lane k PC of the retiring instruction
- rf_we_o  out  1  restore write strobe to all lanes
- rf_addr_o  out  ADDR_WIDTH  restore address
- rf_data_o  out  DATA_WIDTH  restore data
- spc_o  out  DATA_WIDTH  checkpointed PC
- resume_o  out  1  one-cycle pulse: lanes reload PC from spc_o and unblock
- fetch_block_o  out  1  lanes must stall fetch and retire
- fault_lane_o  out  NUM_LANES  sticky flag: lane k was outvoted (TMR only)
- fatal_o  out  1  sticky unrecoverable-fault flag
- err_cnt_o  out  CNT_WIDTH  saturating count of detected mismatches

Behaviour:
- Reset: all outputs 0; shadow RF all 0; spc_o 0; FSM in IDLE; retry counter 0. Reset mid-restore aborts immediately to IDLE.
- Lane tuple T_k = {commit, we, addr, data, pc}.
  - addr/data are masked to 0 when we=0.
  - pc is masked to 0 when commit=0.
  - No comparison is made when all commit_i are 0.
- Vote (combinational, IDLE only):
  - agree: all tuples equal.
  - masked (TMR only): exactly two tuples equal; the odd lane is identified.
  - error: DMR with the two tuples unequal, or TMR with all three distinct.
- On agree or masked, using the agreed tuple:
  - Shadow RF write when we=1 and addr!=0; address 0 is never written and reads as 0.
  - spc_o <= pc.
  - Both updates are visible the next cycle.
  - Retry counter cleared.
- On masked: fault_lane_o[odd] set (sticky); err_cnt_o increments.
- On error:
  - err_cnt_o increments; shadow RF and spc_o are unchanged.
  - If retry counter == MAX_RETRY, go to FATAL.
  - Otherwise increment the retry counter and go to BLOCK.
- err_cnt_o saturates at all-ones.
- FSM states:
  - IDLE: fetch_block_o=0; vote as above.
  - BLOCK: fetch_block_o=1. Stay while any commit_i=1 (drain); go to RESTORE in the first cycle with commit_i all 0.
  - RESTORE:
    - fetch_block_o=1, rf_we_o=1.
    - rf_addr_o steps 0..2**ADDR_WIDTH-1, one per cycle; rf_data_o = shadow RF at rf_addr_o, same cycle.
    - Leaves after the last address; takes exactly 2**ADDR_WIDTH cycles.
  - RESUME: fetch_block_o=1, resume_o=1 for exactly one cycle; then IDLE.
  - FATAL: fetch_block_o=1, fatal_o=1; stays until reset.
- All FSM outputs are registered: fetch_block_o rises in the cycle after the failing compare.
- Outside IDLE, commit_i/we_i/addr_i/data_i/pc_i are ignored: no vote, no shadow update, no counter change.
- A shadow-RF write and a restore read never coincide, because restore happens only outside IDLE.
- Restore reads use a combinational read port, not registered.

Decomposition:
- Package ft_pkg holds:
  - FSM state enum (IDLE, BLOCK, RESTORE, RESUME, FATAL).
  - vote result enum (AGREE, MASKED, ERROR, NONE).
  - Constants RF_DEPTH and LANE_DMR/LANE_TMR.
- Sub-module ft_voter: purely combinational.
  - Inputs: packed tuples.
  - Outputs: vote result, agreed tuple fields, odd-lane one-hot.
- Shadow RF and FSM stay in the top.

Test Plan:
- TMR, all lanes commit we=1 addr=5 data=0xDEADBEEF pc=0x100 -> next cycle spc_o=0x100; a later restore shows rf_addr_o=5 with rf_data_o=0xDEADBEEF; err_cnt_o=0.
- TMR, lane 1 data=0x1 and lanes 0/2 data=0xAA at addr=3 -> shadow[3]=0xAA; fault_lane_o=3'b010; err_cnt_o=1; fetch_block_o stays 0.
- DMR, lane data differs at pc=0x200 -> fetch_block_o=1 next cycle; exactly 32 rf_we_o cycles with addresses 0..31; resume_o pulses once with spc_o equal to the last agreed PC; fetch_block_o=0 the cycle after.
- Error while commit_i stays high 3 cycles -> BLOCK holds 3 cycles before rf_we_o first asserts; err_cnt_o increments only once.
- MAX_RETRY=3 with 4 consecutive errors and no agreed commit between -> after the 4th, fatal_o=1 and fetch_block_o=1 permanently; an agreed commit between errors resets the count instead.
- rst_n low mid-RESTORE (rf_addr_o=10) -> all outputs 0 immediately; shadow RF 0; an agree in IDLE after release works normally.
